// File: rtl/video_sched_pkg.sv
// Shared types and constants for the video stream scheduler.
// Pixel word, scheduler states and the colour-bar palette.
package video_sched_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } state_t;

  localparam pixel_t BAR_COLORS [8] = '{
    24'hFFFFFF,
    24'hFFFF00,
    24'h00FFFF,
    24'h00FF00,
    24'hFF00FF,
    24'hFF0000,
    24'h0000FF,
    24'h000000
  };

endpackage

// File: rtl/video_stream_sched_if.sv
// Control, sync, FIFO and pixel signals of the scheduler.
// slave = scheduler side, master = environment side.
interface video_stream_sched_if #(
  parameter int POS_W = 12
);

  logic                      ClkLocked;
  logic                      EnReq;
  logic                      SrcSelReq;
  logic                      VideoVS;
  logic                      VideoReq;
  logic [POS_W-1:0]          VideoXPos;
  logic                      FifoEmpty;
  video_sched_pkg::pixel_t   FifoData;
  logic                      FifoRd;
  logic                      VideoEn;
  video_sched_pkg::pixel_t   VideoDin;
  logic                      Running;
  logic                      ActiveSrc;
  logic                      Underflow;

  modport slave (
    input  ClkLocked,
    input  EnReq,
    input  SrcSelReq,
    input  VideoVS,
    input  VideoReq,
    input  VideoXPos,
    input  FifoEmpty,
    input  FifoData,
    output FifoRd,
    output VideoEn,
    output VideoDin,
    output Running,
    output ActiveSrc,
    output Underflow
  );

  modport master (
    output ClkLocked,
    output EnReq,
    output SrcSelReq,
    output VideoVS,
    output VideoReq,
    output VideoXPos,
    output FifoEmpty,
    output FifoData,
    input  FifoRd,
    input  VideoEn,
    input  VideoDin,
    input  Running,
    input  ActiveSrc,
    input  Underflow
  );

endinterface

// File: rtl/video_colorbar_gen.sv
// Eight vertical colour bars across the active line.
// Output is registered; zero when not enabled.
module video_colorbar_gen
  import video_sched_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int POS_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [POS_W-1:0] x_pos,
  output pixel_t           pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [POS_W-1:0] idx_full;
  logic [2:0]       idx;

  // Bar index from x position, clamped past the last bar.
  always_comb begin
    idx_full = x_pos / POS_W'(BAR_W);
    idx      = (idx_full > POS_W'(7)) ?
               3'd7 : idx_full[2:0];
  end

  // Register the bar colour for the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel <= '0;
    end else begin
      pixel <= en ? BAR_COLORS[idx] : '0;
    end
  end

endmodule

// File: rtl/video_stream_sched.sv
// Video start/stop sequencing on frame boundaries and
// pixel source arbitration between colour bars and FIFO.
module video_stream_sched
  import video_sched_pkg::*;
#(
  parameter int LOCK_CYCLES = 1024,
  parameter int H_ACTIVE    = 1280,
  parameter bit VS_POL      = 1'b1,
  parameter int POS_W       = 12
) (
  input logic                 PixelClk,
  input logic                 RstB,
  video_stream_sched_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(LOCK_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] lock_cnt;
  logic             vs_q;
  logic             fs;
  logic             in_run;
  logic             fifo_req;
  logic             pop;
  logic             bar_en;
  pixel_t           bar_pix;
  pixel_t           fifo_pix;

  assign fs = (bus.VideoVS == VS_POL) &&
              (vs_q != VS_POL);

  // Delayed VS for frame-start edge detection.
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      vs_q <= ~VS_POL;
    end else begin
      vs_q <= bus.VideoVS;
    end
  end

  // Saturating count of consecutive locked cycles.
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      lock_cnt <= '0;
    end else if (!bus.ClkLocked) begin
      lock_cnt <= '0;
    end else if (lock_cnt != CNT_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Sequencer with registered enable/status outputs.
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      state         <= IDLE;
      bus.VideoEn   <= 1'b0;
      bus.Running   <= 1'b0;
      bus.ActiveSrc <= 1'b0;
    end else if (!bus.ClkLocked) begin
      state       <= IDLE;
      bus.VideoEn <= 1'b0;
      bus.Running <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.EnReq && lock_cnt == CNT_MAX) begin
            state       <= START;
            bus.VideoEn <= 1'b1;
          end
        end
        START: begin
          if (!bus.EnReq) begin
            state       <= IDLE;
            bus.VideoEn <= 1'b0;
          end else if (fs) begin
            state         <= RUN;
            bus.Running   <= 1'b1;
            bus.ActiveSrc <= bus.SrcSelReq;
          end
        end
        RUN: begin
          if (fs) begin
            bus.ActiveSrc <= bus.SrcSelReq;
          end
          if (!bus.EnReq) begin
            state       <= STOP;
            bus.Running <= 1'b0;
          end
        end
        STOP: begin
          if (fs) begin
            state       <= IDLE;
            bus.VideoEn <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.VideoEn <= 1'b0;
          bus.Running <= 1'b0;
        end
      endcase
    end
  end

  assign in_run   = (state == RUN);
  assign fifo_req = bus.VideoReq & bus.ActiveSrc & in_run;
  assign pop      = fifo_req & ~bus.FifoEmpty;
  assign bar_en   = bus.VideoReq & ~bus.ActiveSrc & in_run;
  assign bus.FifoRd = pop;

  video_colorbar_gen #(
    .H_ACTIVE (H_ACTIVE),
    .POS_W    (POS_W)
  ) u_bars (
    .clk   (PixelClk),
    .rst_n (RstB),
    .en    (bar_en),
    .x_pos (bus.VideoXPos),
    .pixel (bar_pix)
  );

  // FIFO pixel capture and sticky underflow.
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      fifo_pix      <= '0;
      bus.Underflow <= 1'b0;
    end else begin
      fifo_pix <= pop ? bus.FifoData : '0;
      if (fifo_req && bus.FifoEmpty) begin
        bus.Underflow <= 1'b1;
      end
    end
  end

  // At most one source register is non-zero.
  assign bus.VideoDin = bar_pix | fifo_pix;

endmodule

// File: tb/tb_video_stream_sched.sv
// Bench for video_stream_sched: lock, start, switch,
// underflow, stop and lock-loss sequences.
module tb_video_stream_sched;

  localparam int LOCK = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [23:0] exp_q [$];
  string       tag_q [$];

  video_stream_sched_if #(.POS_W(12)) bus ();

  video_stream_sched #(
    .LOCK_CYCLES (LOCK),
    .H_ACTIVE    (1280),
    .VS_POL      (1'b1),
    .POS_W       (12)
  ) dut (
    .PixelClk (clk),
    .RstB     (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bar_ref(int x);
    if (x < 160)       return 24'hFFFFFF;
    else if (x < 320)  return 24'hFFFF00;
    else if (x < 480)  return 24'h00FFFF;
    else if (x < 640)  return 24'h00FF00;
    else if (x < 800)  return 24'hFF00FF;
    else if (x < 960)  return 24'hFF0000;
    else if (x < 1120) return 24'h0000FF;
    else               return 24'h000000;
  endfunction

  task automatic pix(input logic req,
                     input int x,
                     input logic [23:0] exp_dout,
                     input logic exp_rd,
                     input string tag);
    logic [23:0] e;
    string t;
    bus.VideoReq  = req;
    bus.VideoXPos = 12'(x);
    #1;
    chk({tag, "_rd"}, 32'(bus.FifoRd), 32'(exp_rd));
    exp_q.push_back(exp_dout);
    tag_q.push_back(tag);
    cycle();
    bus.VideoReq = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(bus.VideoDin), 32'(e));
    end
  endtask

  task automatic qualify(input string tag);
    int early;
    early = 0;
    for (int k = 1; k <= LOCK; k++) begin
      cycle();
      if (bus.VideoEn) early++;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    cycle();
    chk({tag, "_en"}, 32'(bus.VideoEn), 32'd1);
  endtask

  task automatic fs_cycle();
    bus.VideoVS = 1'b1;
    cycle();
    bus.VideoVS = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int early;
    bus.ClkLocked = 1'b0;
    bus.EnReq     = 1'b0;
    bus.SrcSelReq = 1'b0;
    bus.VideoVS   = 1'b0;
    bus.VideoReq  = 1'b0;
    bus.VideoXPos = '0;
    bus.FifoEmpty = 1'b1;
    bus.FifoData  = '0;

    cycle();
    cycle();
    chk("rst_en", 32'(bus.VideoEn), 32'd0);
    chk("rst_run", 32'(bus.Running), 32'd0);
    chk("rst_src", 32'(bus.ActiveSrc), 32'd0);
    chk("rst_uf", 32'(bus.Underflow), 32'd0);
    chk("rst_din", 32'(bus.VideoDin), 32'd0);
    chk("rst_rd", 32'(bus.FifoRd), 32'd0);
    rst_n = 1'b1;

    bus.EnReq     = 1'b1;
    bus.ClkLocked = 1'b1;
    early = 0;
    repeat (1000) begin
      cycle();
      if (bus.VideoEn) early++;
    end
    chk("prelock_early", 32'(early), 32'd0);
    bus.ClkLocked = 1'b0;
    cycle();
    chk("lockdrop_en", 32'(bus.VideoEn), 32'd0);
    bus.ClkLocked = 1'b1;
    qualify("lock");

    pix(1'b1, 0, 24'h0, 1'b0, "start_x0");
    pix(1'b1, 500, 24'h0, 1'b0, "start_x500");
    chk("start_run", 32'(bus.Running), 32'd0);
    bus.VideoVS = 1'b1;
    pix(1'b1, 0, 24'h0, 1'b0, "fs_req");
    bus.VideoVS = 1'b0;
    chk("run_rise", 32'(bus.Running), 32'd1);
    chk("run_src", 32'(bus.ActiveSrc), 32'd0);
    pix(1'b1, 0, bar_ref(0), 1'b0, "bar_x0");
    pix(1'b1, 1279, bar_ref(1279), 1'b0, "bar_x1279");
    pix(1'b1, 160, bar_ref(160), 1'b0, "bar_x160");
    pix(1'b1, 159, bar_ref(159), 1'b0, "bar_x159");
    pix(1'b1, 1119, bar_ref(1119), 1'b0, "bar_x1119");
    pix(1'b1, 700, bar_ref(700), 1'b0, "bar_x700");
    pix(1'b1, 4000, 24'h000000, 1'b0, "bar_clamp");
    pix(1'b0, 160, 24'h0, 1'b0, "bar_noreq");

    bus.FifoEmpty = 1'b0;
    bus.FifoData  = 24'hDEADBE;
    bus.SrcSelReq = 1'b1;
    pix(1'b1, 160, bar_ref(160), 1'b0, "sw_pre");
    chk("sw_pre_src", 32'(bus.ActiveSrc), 32'd0);
    bus.VideoVS = 1'b1;
    pix(1'b1, 0, bar_ref(0), 1'b0, "sw_fs");
    bus.VideoVS = 1'b0;
    chk("sw_src", 32'(bus.ActiveSrc), 32'd1);
    pix(1'b1, 5, 24'hDEADBE, 1'b1, "fifo_a");
    pix(1'b1, 6, 24'hDEADBE, 1'b1, "fifo_b");
    pix(1'b0, 7, 24'h0, 1'b0, "fifo_idle");
    bus.FifoData = 24'h123456;
    pix(1'b1, 8, 24'h123456, 1'b1, "fifo_c");
    bus.FifoData = 24'hDEADBE;

    chk("uf_pre", 32'(bus.Underflow), 32'd0);
    bus.FifoEmpty = 1'b1;
    pix(1'b1, 10, 24'h0, 1'b0, "uf_pix");
    chk("uf_set", 32'(bus.Underflow), 32'd1);
    bus.FifoEmpty = 1'b0;
    pix(1'b1, 11, 24'hDEADBE, 1'b1, "uf_refill");
    chk("uf_sticky", 32'(bus.Underflow), 32'd1);
    bus.VideoVS = 1'b1;
    pix(1'b0, 0, 24'h0, 1'b0, "uf_fs");
    bus.VideoVS = 1'b0;
    chk("uf_fs_keep", 32'(bus.Underflow), 32'd1);

    bus.EnReq = 1'b0;
    pix(1'b0, 0, 24'h0, 1'b0, "stop_req");
    chk("stop_run", 32'(bus.Running), 32'd0);
    chk("stop_en", 32'(bus.VideoEn), 32'd1);
    bus.EnReq = 1'b1;
    pix(1'b1, 3, 24'h0, 1'b0, "stop_pix_a");
    pix(1'b1, 4, 24'h0, 1'b0, "stop_pix_b");
    chk("stop_reen", 32'(bus.Running), 32'd0);
    bus.EnReq = 1'b0;
    repeat (3) cycle();
    chk("stop_hold", 32'(bus.VideoEn), 32'd1);
    fs_cycle();
    chk("stop_done_en", 32'(bus.VideoEn), 32'd0);
    chk("stop_done_run", 32'(bus.Running), 32'd0);

    bus.EnReq     = 1'b1;
    bus.SrcSelReq = 1'b0;
    cycle();
    chk("restart_en", 32'(bus.VideoEn), 32'd1);
    fs_cycle();
    chk("restart_run", 32'(bus.Running), 32'd1);
    chk("restart_src", 32'(bus.ActiveSrc), 32'd0);
    repeat (2) cycle();
    bus.EnReq = 1'b0;
    fs_cycle();
    chk("fsstop_run", 32'(bus.Running), 32'd0);
    chk("fsstop_en", 32'(bus.VideoEn), 32'd1);
    repeat (3) cycle();
    chk("fsstop_hold", 32'(bus.VideoEn), 32'd1);
    fs_cycle();
    chk("fsstop_done", 32'(bus.VideoEn), 32'd0);

    bus.EnReq = 1'b1;
    cycle();
    fs_cycle();
    chk("ll_run", 32'(bus.Running), 32'd1);
    bus.ClkLocked = 1'b0;
    cycle();
    chk("ll_en", 32'(bus.VideoEn), 32'd0);
    chk("ll_run0", 32'(bus.Running), 32'd0);
    bus.ClkLocked = 1'b1;
    qualify("relock");
    chk("relock_run", 32'(bus.Running), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
